// File: rtl/mux16_to_1.sv
// 16:1 single-bit multiplexer built as a balanced 4-level 2:1 tree, with an
// optional enable-gated output register selected by OUT_REG.
module mux16_to_1 #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic [3:0]  select,
  input  logic        en,
  output logic        out,
  output logic        out_valid
);

  localparam int unsigned L1_W = 8;
  localparam int unsigned L2_W = 4;
  localparam int unsigned L3_W = 2;

  logic [L1_W-1:0] lvl1;
  logic [L2_W-1:0] lvl2;
  logic [L3_W-1:0] lvl3;
  logic            sel_bit;

  // Ternary selects keep an X on any select bit visible in simulation.
  for (genvar i = 0; i < int'(L1_W); i++) begin : g_lvl1
    assign lvl1[i] = select[0] ? in[2*i+1] : in[2*i];
  end

  for (genvar i = 0; i < int'(L2_W); i++) begin : g_lvl2
    assign lvl2[i] = select[1] ? lvl1[2*i+1] : lvl1[2*i];
  end

  for (genvar i = 0; i < int'(L3_W); i++) begin : g_lvl3
    assign lvl3[i] = select[2] ? lvl2[2*i+1] : lvl2[2*i];
  end

  assign sel_bit = select[3] ? lvl3[1] : lvl3[0];

  if (OUT_REG) begin : g_reg
    logic out_q;
    logic valid_q;

    // Capture on enable; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q   <= 1'b0;
        valid_q <= 1'b0;
      end else if (en) begin
        out_q   <= sel_bit;
        valid_q <= 1'b1;
      end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = ^{clk, en};

    // Data path stays live through reset; only the valid flag is gated.
    assign out       = sel_bit;
    assign out_valid = rst_n;
  end

endmodule

// File: tb/tb_mux16_to_1.sv
// Randomized and directed bench for mux16_to_1 in both registered and
// combinational builds, checked against a simple behavioural model.
module tb_mux16_to_1;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [3:0]  sel;
  logic        en;
  logic        out_r, valid_r;
  logic        out_c, valid_c;

  int unsigned n_checks;
  int unsigned n_fail;

  logic m_out;
  logic m_valid;

  mux16_to_1 #(.OUT_REG(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in(din), .select(sel), .en(en),
    .out(out_r), .out_valid(valid_r)
  );

  mux16_to_1 #(.OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(din), .select(sel), .en(en),
    .out(out_c), .out_valid(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_bit(input logic [15:0] d, input logic [3:0] s);
    logic [15:0] sh;
    sh = d >> s;
    return sh[0];
  endfunction

  task automatic check_comb();
    check("comb_out", 32'(out_c), 32'(ref_bit(din, sel)));
    check("comb_valid", 32'(valid_c), 32'(rst_n));
  endtask

  // One clock edge: advance the model with the inputs currently applied, then compare.
  task automatic step();
    if (rst_n && en) begin
      m_out   = ref_bit(din, sel);
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("reg_out", 32'(out_r), 32'(m_out));
    check("reg_valid", 32'(valid_r), 32'(m_valid));
    check_comb();
  endtask

  // Drop reset between edges and observe the effect before the next edge.
  task automatic async_reset(input logic en_during);
    en    = en_during;
    #1;
    rst_n = 1'b0;
    m_out   = 1'b0;
    m_valid = 1'b0;
    #1;
    check("rst_out", 32'(out_r), 32'd0);
    check("rst_valid", 32'(valid_r), 32'd0);
    check_comb();
    @(posedge clk);
    #1;
    check("rst_hold_out", 32'(out_r), 32'd0);
    check("rst_hold_valid", 32'(valid_r), 32'd0);
    rst_n = 1'b1;
    #1;
    check_comb();
  endtask

  initial begin
    logic [15:0] sweep_sel;
    logic        sweep_exp [5];
    logic [3:0]  sweep_tab [5];

    n_checks = 0;
    n_fail   = 0;
    m_out    = 1'b0;
    m_valid  = 1'b0;
    rst_n    = 1'b0;
    din      = 16'h1234;
    sel      = 4'd2;
    en       = 1'b1;

    // Reset state, including across a clock edge with en=1.
    #2;
    check("init_out", 32'(out_r), 32'd0);
    check("init_valid", 32'(valid_r), 32'd0);
    check_comb();
    step();
    rst_n = 1'b1;

    // Selection sweep.
    sweep_tab[0] = 4'h0; sweep_exp[0] = 1'b0;
    sweep_tab[1] = 4'h1; sweep_exp[1] = 1'b1;
    sweep_tab[2] = 4'h4; sweep_exp[2] = 1'b0;
    sweep_tab[3] = 4'h6; sweep_exp[3] = 1'b0;
    sweep_tab[4] = 4'hC; sweep_exp[4] = 1'b1;
    din = 16'h3F0A;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = sweep_tab[i];
      step();
      check("sweep_out", 32'(out_r), 32'(sweep_exp[i]));
      check("sweep_valid", 32'(valid_r), 32'd1);
    end
    sweep_sel = 16'h0;

    // Exhaustive one-hot: every select sees both a 1 and a 0.
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        din = 16'd1 << k;
        sel = 4'(s);
        step();
        check("onehot", 32'(out_r), 32'(s == k));
      end
    end

    // Hold directed case.
    din = 16'hFFFF; sel = 4'd3; en = 1'b1;
    step();
    en = 1'b0; din = 16'h0000;
    step();
    check("hold_ffff", 32'(out_r), 32'd1);
    step();
    check("hold_ffff2", 32'(out_r), 32'd1);

    // en=0 hold on every select value.
    for (int s = 0; s < 16; s++) begin
      din = 16'($urandom); sel = 4'(s); en = 1'b1;
      step();
      din = ~din; sel = 4'($urandom); en = 1'b0;
      step();
      check("hold_sel", 32'(out_r), 32'(ref_bit(~din, 4'(s))));
    end

    // Async reset with out=1, during en=1 and during en=0.
    din = 16'h0008; sel = 4'd3; en = 1'b1;
    step();
    check("pre_rst_out", 32'(out_r), 32'd1);
    async_reset(1'b1);
    en = 1'b1; din = 16'h0020; sel = 4'd5;
    step();
    check("post_rst_out", 32'(out_r), 32'd1);
    check("post_rst_valid", 32'(valid_r), 32'd1);
    async_reset(1'b0);
    din = 16'h0000; en = 1'b0;
    step();
    check("post_rst_en0_valid", 32'(valid_r), 32'd0);
    en = 1'b1;
    step();

    // Combinational build with no clock edges between changes.
    @(negedge clk);
    din = 16'h8001;
    sel = 4'hF; #1; check("comb_f", 32'(out_c), 32'd1);
    sel = 4'h0; #1; check("comb_0", 32'(out_c), 32'd1);
    sel = 4'h7; #1; check("comb_7", 32'(out_c), 32'd0);

    // Randomized traffic with concurrent in/select changes and sporadic resets.
    for (int i = 0; i < 400; i++) begin
      din = 16'($urandom);
      sel = 4'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0)
        async_reset(1'($urandom));
      else
        step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
